// File: rtl/bus_halt_ctrl.sv
// rtl/bus_halt_ctrl.sv - per-channel CPU halt/stall controller with wait states and busy watchdog
//
// Decodes each CPU access (rd_i|we_i) against NUM_CH address windows and stalls the
// CPU via halt_o for the channel's fixed wait states. When the channel has busy_en_i set,
// the halt is then stretched while module_busy_i is high. A watchdog bounds that stretch.
// ext_halt_i is OR'ed straight into halt_o and never touches the FSM.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_ni         synchronous active-low reset
//   address_i        CPU bus address, valid with rd_i/we_i
//   rd_i, we_i       one-cycle access strobes
//   busy_en_i        per-channel enable for busy stretching
//   module_busy_i    per-channel busy from the slave modules
//   ext_halt_i       external halt request
//   clear_flags_i    clears timeout_flags_o
//   halt_o           to the CPU halt input
//   active_ch_o      channel owning the current stall, 0 when idle
//   timeout_o        one-cycle pulse on watchdog expiry
//   timeout_flags_o  sticky per-channel timeout flags

module bus_halt_ctrl #(
  parameter int                       NUM_CH  = 4,
  parameter int                       ADDR_W  = 32,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = '0,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_MASK = '0,
  parameter logic [NUM_CH*4-1:0]      CH_WS   = '0,
  parameter int                       TIMEOUT = 255,
  parameter int                       TO_W    = $clog2(TIMEOUT+1)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              rd_i,
  input  logic              we_i,
  input  logic [NUM_CH-1:0] busy_en_i,
  input  logic [NUM_CH-1:0] module_busy_i,
  input  logic              ext_halt_i,
  input  logic              clear_flags_i,
  output logic              halt_o,
  output logic [3:0]        active_ch_o,
  output logic              timeout_o,
  output logic [NUM_CH-1:0] timeout_flags_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BUSY
  } state_t;

  state_t          state;
  logic [3:0]      ws_cnt;
  logic [TO_W-1:0] to_cnt;

  // Decode of the current access; the winning channel's parameters are
  // captured inside the loop so no variable-width part-select is needed.
  logic       hit_any;
  logic [3:0] hit_ch;
  logic [3:0] hit_ws;
  logic       hit_busy_en;
  logic       access;
  logic       stall_hit;

  // Inputs of the channel currently latched in active_ch_o.
  logic              act_busy_en;
  logic              act_busy;
  logic [NUM_CH-1:0] act_onehot;

  logic busy_grace;
  logic expire;

  assign access = rd_i | we_i;

  // Scan from the top so the lowest-index hit is the last to write.
  always_comb begin
    hit_any     = 1'b0;
    hit_ch      = 4'd0;
    hit_ws      = 4'd0;
    hit_busy_en = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if ((address_i & CH_MASK[c*ADDR_W +: ADDR_W]) ==
          (CH_BASE[c*ADDR_W +: ADDR_W] & CH_MASK[c*ADDR_W +: ADDR_W])) begin
        hit_any     = 1'b1;
        hit_ch      = 4'(c);
        hit_ws      = CH_WS[c*4 +: 4];
        hit_busy_en = busy_en_i[c];
      end
    end
  end

  // Only the winning channel is considered; a non-stalling winner means no action.
  assign stall_hit = access & hit_any & ((hit_ws != 4'd0) | hit_busy_en);

  always_comb begin
    act_busy_en = 1'b0;
    act_busy    = 1'b0;
    act_onehot  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (active_ch_o == 4'(c)) begin
        act_busy_en   = busy_en_i[c];
        act_busy      = module_busy_i[c];
        act_onehot[c] = 1'b1;
      end
    end
  end

  // to_cnt holds the 1-based index of the current BUSY cycle; cycle 1 is the
  // grace cycle in which module_busy_i is not looked at.
  assign busy_grace = (to_cnt == TO_W'(1));
  assign expire     = (state == ST_BUSY) & ~busy_grace & act_busy &
                      (to_cnt == TO_W'(TIMEOUT));

  // The access cycle itself must already halt the CPU, hence the combinational
  // stall_hit term. Reset masks everything except the external request.
  assign halt_o = ext_halt_i | (reset_ni & ((state != ST_IDLE) | stall_hit));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state           <= ST_IDLE;
      ws_cnt          <= 4'd0;
      to_cnt          <= '0;
      active_ch_o     <= 4'd0;
      timeout_o       <= 1'b0;
      timeout_flags_o <= '0;
    end else begin
      timeout_o <= 1'b0;

      // A timeout on a channel wins over a simultaneous clear of that channel.
      timeout_flags_o <= (clear_flags_i ? '0 : timeout_flags_o) |
                         (expire ? act_onehot : '0);

      case (state)
        ST_IDLE: begin
          if (stall_hit) begin
            active_ch_o <= hit_ch;
            if (hit_ws != 4'd0) begin
              state  <= ST_WAIT;
              // Counts down to 0 so WAIT lasts exactly hit_ws cycles.
              ws_cnt <= hit_ws - 4'd1;
            end else begin
              state  <= ST_BUSY;
              to_cnt <= TO_W'(1);
            end
          end
        end

        ST_WAIT: begin
          if (ws_cnt == 4'd0) begin
            if (act_busy_en) begin
              state  <= ST_BUSY;
              to_cnt <= TO_W'(1);
            end else begin
              state       <= ST_IDLE;
              active_ch_o <= 4'd0;
            end
          end else begin
            ws_cnt <= ws_cnt - 4'd1;
          end
        end

        ST_BUSY: begin
          if (busy_grace) begin
            to_cnt <= to_cnt + TO_W'(1);
          end else if (!act_busy) begin
            state       <= ST_IDLE;
            active_ch_o <= 4'd0;
            to_cnt      <= '0;
          end else if (expire) begin
            state       <= ST_IDLE;
            active_ch_o <= 4'd0;
            to_cnt      <= '0;
            timeout_o   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: begin
          state       <= ST_IDLE;
          active_ch_o <= 4'd0;
          to_cnt      <= '0;
          ws_cnt      <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_halt_ctrl.sv
// tb/tb_bus_halt_ctrl.sv - self-checking bench for bus_halt_ctrl

module tb_bus_halt_ctrl;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;

  // ch0 0x1000 WS0, ch1 0x2000 WS3, ch2 0x3000 WS1, ch3 0x2000..0x20FF WS2 (inside ch1)
  localparam logic [NUM_CH*ADDR_W-1:0] BASE = {32'h0000_2000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
  localparam logic [NUM_CH*ADDR_W-1:0] MASK = {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [NUM_CH*4-1:0]      WS   = {4'd2, 4'd1, 4'd3, 4'd0};

  logic              clk = 1'b0;
  logic              reset_ni;
  logic [ADDR_W-1:0] address_i;
  logic              rd_i, we_i;
  logic [NUM_CH-1:0] busy_en_i, module_busy_i;
  logic              ext_halt_i, clear_flags_i;
  logic              halt_o;
  logic [3:0]        active_ch_o;
  logic              timeout_o;
  logic [NUM_CH-1:0] timeout_flags_o;

  bus_halt_ctrl #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .CH_BASE(BASE),
    .CH_MASK(MASK),
    .CH_WS  (WS),
    .TIMEOUT(8)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .address_i      (address_i),
    .rd_i           (rd_i),
    .we_i           (we_i),
    .busy_en_i      (busy_en_i),
    .module_busy_i  (module_busy_i),
    .ext_halt_i     (ext_halt_i),
    .clear_flags_i  (clear_flags_i),
    .halt_o         (halt_o),
    .active_ch_o    (active_ch_o),
    .timeout_o      (timeout_o),
    .timeout_flags_o(timeout_flags_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rd;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [3:0]  mb;
    logic        ext;
    logic        clr;
    logic        e_halt;
    logic [3:0]  e_ch;
    logic        e_to;
    logic [3:0]  e_fl;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  function automatic vec_t mk(logic rd, logic we, logic [31:0] addr, logic [3:0] be,
                              logic [3:0] mb, logic ext, logic clr, logic e_halt,
                              logic [3:0] e_ch, logic e_to, logic [3:0] e_fl);
    vec_t v;
    v.rst_n = 1'b1; v.rd = rd; v.we = we; v.addr = addr; v.be = be; v.mb = mb;
    v.ext = ext; v.clr = clr; v.e_halt = e_halt; v.e_ch = e_ch; v.e_to = e_to; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0h expected %0h", step_no, nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic step(input vec_t v);
    @(posedge clk); #1;
    reset_ni      = v.rst_n;
    rd_i          = v.rd;
    we_i          = v.we;
    address_i     = v.addr;
    busy_en_i     = v.be;
    module_busy_i = v.mb;
    ext_halt_i    = v.ext;
    clear_flags_i = v.clr;
    @(negedge clk);
    chk("halt_o", 32'(halt_o), 32'(v.e_halt));
    chk("active_ch_o", 32'(active_ch_o), 32'(v.e_ch));
    chk("timeout_o", 32'(timeout_o), 32'(v.e_to));
    chk("timeout_flags_o", 32'(timeout_flags_o), 32'(v.e_fl));
    step_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    reset_ni = 1'b0; rd_i = 1'b0; we_i = 1'b0; address_i = '0;
    busy_en_i = '0; module_busy_i = '0; ext_halt_i = 1'b0; clear_flags_i = 1'b0;

    // Reset state, with ext_halt_i visible through reset
    v = mk(0,0,0,0,0, 0,0, 0,0,0,4'b0000); v.rst_n = 1'b0; step(v);
    v = mk(0,0,32'h2400,0,0, 1,0, 1,0,0,4'b0000); v.rst_n = 1'b0; v.we = 1'b1; step(v);

    // A: ch1 WS3 single write, access during WAIT ignored
    vecs.push_back(mk(0,1,32'h2400,4'h0,4'h0, 0,0, 1,4'd0,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 1,4'd1,0,4'h0));
    vecs.push_back(mk(1,0,32'h3000,4'h0,4'h0, 0,0, 1,4'd1,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 1,4'd1,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 0,4'd0,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 0,4'd0,0,4'h0));
    // Non-stalling hit (ch0 WS0, busy disabled) and a miss
    vecs.push_back(mk(1,0,32'h1000,4'h0,4'h0, 0,0, 0,4'd0,0,4'h0));
    vecs.push_back(mk(1,0,32'h9000,4'hF,4'h0, 0,0, 0,4'd0,0,4'h0));
    // B: ch0 busy stretch, busy high 5 cycles after the access
    vecs.push_back(mk(1,0,32'h1010,4'h1,4'h0, 0,0, 1,4'd0,0,4'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,32'h0000,4'h1,4'h1, 0,0, 1,4'd0,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h1,4'h0, 0,0, 1,4'd0,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h1,4'h0, 0,0, 0,4'd0,0,4'h0));
    // C: ch2 WS1 then busy stuck -> watchdog after 8 BUSY cycles
    vecs.push_back(mk(0,1,32'h3000,4'h4,4'h4, 0,0, 1,4'd0,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 1,4'd2,0,4'h0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 1,4'd2,0,4'h0));
    vecs.push_back(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 0,4'd0,1,4'h4));
    vecs.push_back(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 0,4'd0,0,4'h4));
    // D: overlapping ch1/ch3 -> ch1 with WS3
    vecs.push_back(mk(1,0,32'h2010,4'h0,4'h0, 0,0, 1,4'd0,0,4'h4));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 1,4'd1,0,4'h4));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 0,4'd0,0,4'h4));
    // E: ext_halt_i in IDLE and during WAIT
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 1,0, 1,4'd0,0,4'h4));
    vecs.push_back(mk(0,1,32'h3000,4'h0,4'h0, 1,0, 1,4'd0,0,4'h4));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 1,0, 1,4'd2,0,4'h4));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 0,4'd0,0,4'h4));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 1,0, 1,4'd0,0,4'h4));
    // F: clear flags
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,1, 0,4'd0,0,4'h4));
    vecs.push_back(mk(0,0,32'h0000,4'h0,4'h0, 0,0, 0,4'd0,0,4'h0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Ch0 timeout (WS0, busy stuck) to set flag bit 0
    step(mk(1,0,32'h1000,4'h1,4'h1, 0,0, 1,4'd0,0,4'h0));
    repeat (8) step(mk(0,0,32'h0000,4'h1,4'h1, 0,0, 1,4'd0,0,4'h0));
    step(mk(0,0,32'h0000,4'h1,4'h1, 0,0, 0,4'd0,1,4'h1));

    // Ch2 timeout with clear_flags_i in the expiry cycle: ch2 set wins, ch0 clears
    step(mk(0,1,32'h3000,4'h4,4'h4, 0,0, 1,4'd0,0,4'h1));
    step(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 1,4'd2,0,4'h1));
    repeat (7) step(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 1,4'd2,0,4'h1));
    step(mk(0,0,32'h0000,4'h4,4'h4, 0,1, 1,4'd2,0,4'h1));
    step(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 0,4'd0,1,4'h4));

    // Reset asserted in the would-be expiry cycle of a ch2 stall
    step(mk(0,1,32'h3000,4'h4,4'h4, 0,0, 1,4'd0,0,4'h4));
    step(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 1,4'd2,0,4'h4));
    repeat (7) step(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 1,4'd2,0,4'h4));
    v = mk(0,0,32'h0000,4'h4,4'h4, 0,0, 0,4'd2,0,4'h4); v.rst_n = 1'b0; step(v);
    step(mk(0,0,32'h0000,4'h4,4'h4, 1,0, 1,4'd0,0,4'h0));
    step(mk(0,0,32'h0000,4'h4,4'h4, 0,0, 0,4'd0,0,4'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
